taxi_sync_handshake_src: RTL and testbench

Source (sending) end of a 4-phase req/ack clock-domain-crossing handshake. It accepts a data word on a valid/ready input and presents it on a stable bus with a level request. It waits for the far-domain acknowledge, which it synchronizes internally with an SYNC_N-stage register chain, then completes the return-to-zero phase. It pairs with the destination-side synchronizer that samples xfer_req and returns xfer_ack.

---
 rtl/taxi_sync_handshake_src.sv | 133 +++++++++++++
 tb/tb_taxi_sync_handshake_src.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/taxi_sync_handshake_src.sv
// Source end of a 4-phase req/ack handshake across clock domains.
// A word accepted on s_valid/s_ready is held on xfer_data while xfer_req is
// high. The far-domain acknowledge is synchronized locally before use, and
// the block returns to IDLE once the acknowledge has dropped again.
module taxi_sync_handshake_src #(
  parameter int DATA_W    = 8,
  parameter int SYNC_N    = 2,
  parameter int TIMEOUT_W = 16,
  parameter int COUNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [DATA_W-1:0]  s_data,
  input  logic               s_valid,
  output logic               s_ready,
  output logic [DATA_W-1:0]  xfer_data,
  output logic               xfer_req,
  input  logic               xfer_ack,
  output logic               busy,
  output logic               timeout,
  input  logic               timeout_clr,
  output logic [COUNT_W-1:0] xfer_count
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    RELEASE = 2'd2
  } state_t;

  localparam logic [TIMEOUT_W-1:0] WAIT_MAX = '1;

  state_t state;
  state_t state_next;

  (* ASYNC_REG = "TRUE", shreg_extract = "no", srl_style = "register" *)
  logic [SYNC_N-1:0] ack_chain;
  logic              ack_sync;

  logic [TIMEOUT_W-1:0] wait_cnt;
  logic [TIMEOUT_W-1:0] wait_cnt_next;
  logic                 timeout_set;
  logic                 accept;
  logic                 req_next;
  logic                 count_inc;

  // Only the final stage of the chain is visible to the rest of the logic.
  assign ack_sync = ack_chain[SYNC_N-1];
  assign s_ready  = (state == IDLE) && !ack_sync;
  assign busy     = (state != IDLE);

  // Synchronizer for the asynchronous acknowledge from the far domain.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ack_chain <= '0;
    end else begin
      ack_chain <= {ack_chain[SYNC_N-2:0], xfer_ack};
    end
  end

  // Next-state, request level and event strobes for the handshake FSM.
  always_comb begin
    state_next = state;
    req_next   = xfer_req;
    accept     = 1'b0;
    count_inc  = 1'b0;
    case (state)
      IDLE: begin
        if (s_valid && s_ready) begin
          accept     = 1'b1;
          req_next   = 1'b1;
          state_next = REQ;
        end
      end
      REQ: begin
        if (ack_sync) begin
          req_next   = 1'b0;
          state_next = RELEASE;
        end
      end
      RELEASE: begin
        if (!ack_sync) begin
          count_inc  = 1'b1;
          state_next = IDLE;
        end
      end
      default: begin
        req_next   = 1'b0;
        state_next = IDLE;
      end
    endcase
  end

  // Wait counter restarts on every phase change and flags the edge it saturates.
  always_comb begin
    wait_cnt_next = wait_cnt;
    timeout_set   = 1'b0;
    if ((state_next != state) || (state == IDLE)) begin
      wait_cnt_next = '0;
    end else if (wait_cnt != WAIT_MAX) begin
      wait_cnt_next = wait_cnt + TIMEOUT_W'(1);
      timeout_set   = (wait_cnt_next == WAIT_MAX);
    end
  end

  // State, outgoing bus, sticky timeout and completed-transfer counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      xfer_req   <= 1'b0;
      xfer_data  <= '0;
      wait_cnt   <= '0;
      timeout    <= 1'b0;
      xfer_count <= '0;
    end else begin
      state    <= state_next;
      xfer_req <= req_next;
      wait_cnt <= wait_cnt_next;
      if (accept) begin
        xfer_data <= s_data;
      end
      if (timeout_set) begin
        timeout <= 1'b1;
      end else if (timeout_clr) begin
        timeout <= 1'b0;
      end
      if (count_inc) begin
        xfer_count <= xfer_count + COUNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_taxi_sync_handshake_src.sv
// Directed self-checking bench for taxi_sync_handshake_src.
// The DUT uses SYNC_N=2, TIMEOUT_W=4 and COUNT_W=2 so that timeout and
// counter wrap are reached within a short run.
module tb_taxi_sync_handshake_src;

  localparam int DATA_W    = 8;
  localparam int SYNC_N    = 2;
  localparam int TIMEOUT_W = 4;
  localparam int COUNT_W   = 2;

  logic              clk;
  logic              rst_n;
  logic [DATA_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] xfer_data;
  logic              xfer_req;
  wire               xfer_ack;
  logic              ack_man;
  logic              auto_ack;
  logic              busy;
  logic              timeout;
  logic              timeout_clr;
  logic [COUNT_W-1:0] xfer_count;

  int checks;
  int passed;

  // Far-end model: either echoes xfer_req with no delay or follows a manual level.
  assign xfer_ack = auto_ack ? xfer_req : ack_man;

  taxi_sync_handshake_src #(
    .DATA_W    (DATA_W),
    .SYNC_N    (SYNC_N),
    .TIMEOUT_W (TIMEOUT_W),
    .COUNT_W   (COUNT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .s_data      (s_data),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .xfer_data   (xfer_data),
    .xfer_req    (xfer_req),
    .xfer_ack    (xfer_ack),
    .busy        (busy),
    .timeout     (timeout),
    .timeout_clr (timeout_clr),
    .xfer_count  (xfer_count)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic valid, input logic [DATA_W-1:0] data,
                               input logic ack, input logic clr);
    s_valid     = valid;
    s_data      = data;
    ack_man     = ack;
    timeout_clr = clr;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) passed++;
    else $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
  endtask

  // Linear sequence of directed scenarios.
  initial begin
    int wait_cycles;
    int busy_cycles;
    checks   = 0;
    passed   = 0;
    auto_ack = 1'b0;
    rst_n    = 1'b0;
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    tick();
    tick();

    // Reset state
    checkOutput("rst_req",   32'(xfer_req),   0);
    checkOutput("rst_data",  32'(xfer_data),  0);
    checkOutput("rst_busy",  32'(busy),       0);
    checkOutput("rst_tmo",   32'(timeout),    0);
    checkOutput("rst_count", 32'(xfer_count), 0);
    checkOutput("rst_ready", 32'(s_ready),    1);
    rst_n = 1'b1;

    // Basic transfer with manual acknowledge
    $display("[TB] basic transfer");
    applyStimulus(1'b1, 8'hA5, 1'b0, 1'b0);
    tick();
    checkOutput("basic_req_up",   32'(xfer_req),  1);
    checkOutput("basic_data",     32'(xfer_data), 32'h A5);
    checkOutput("basic_busy",     32'(busy),      1);
    checkOutput("basic_notready", 32'(s_ready),   0);
    applyStimulus(1'b0, 8'h3C, 1'b0, 1'b0);
    tick();
    tick();
    applyStimulus(1'b0, 8'h3C, 1'b1, 1'b0);
    tick();
    checkOutput("basic_req_e1", 32'(xfer_req), 1);
    tick();
    checkOutput("basic_req_e2", 32'(xfer_req), 1);
    tick();
    checkOutput("basic_req_fall", 32'(xfer_req),  0);
    checkOutput("basic_rel_busy", 32'(busy),      1);
    checkOutput("basic_hold",     32'(xfer_data), 32'h A5);
    applyStimulus(1'b0, 8'h3C, 1'b0, 1'b0);
    tick();
    tick();
    checkOutput("basic_cnt_pend", 32'(xfer_count), 0);
    checkOutput("basic_busy_rel", 32'(busy),       1);
    tick();
    checkOutput("basic_count", 32'(xfer_count), 1);
    checkOutput("basic_idle",  32'(busy),       0);
    checkOutput("basic_ready", 32'(s_ready),    1);
    checkOutput("basic_keep",  32'(xfer_data),  32'h A5);

    // Back-to-back stream with immediate far-end ack; also covers count wrap
    $display("[TB] back-to-back stream");
    rst_n = 1'b0;
    tick();
    rst_n    = 1'b1;
    auto_ack = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      applyStimulus(1'b1, DATA_W'(k), 1'b0, 1'b0);
      wait_cycles = 0;
      while (!s_ready && wait_cycles < 20) begin
        tick();
        wait_cycles++;
      end
      checkOutput("b2b_ready_wait", 32'(s_ready), 1);
      tick();
      checkOutput("b2b_data", 32'(xfer_data), 32'(k));
      checkOutput("b2b_req",  32'(xfer_req),  1);
      applyStimulus(1'b1, 8'hEE, 1'b0, 1'b0);
      busy_cycles = 0;
      while (busy && busy_cycles < 40) begin
        busy_cycles++;
        tick();
      end
      // A zero-delay far end keeps the block busy for 2*SYNC_N+2 cycles
      checkOutput("b2b_busy_len", 32'(busy_cycles), 32'(2 * SYNC_N + 2));
      checkOutput("b2b_hold",     32'(xfer_data),   32'(k));
      checkOutput("b2b_count",    32'(xfer_count),  32'(k % 4));
    end
    auto_ack = 1'b0;
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);

    // Timeout while the far end never answers
    $display("[TB] timeout");
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    applyStimulus(1'b1, 8'h5A, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 14; i++) tick();
    checkOutput("tmo_before", 32'(timeout), 0);
    tick();
    checkOutput("tmo_set",      32'(timeout),  1);
    checkOutput("tmo_req_held", 32'(xfer_req), 1);
    checkOutput("tmo_busy",     32'(busy),     1);
    tick();
    tick();
    tick();
    checkOutput("tmo_sticky", 32'(timeout), 1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("tmo_cleared", 32'(timeout), 0);
    tick();
    tick();
    checkOutput("tmo_no_reset", 32'(timeout), 0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    tick();
    tick();
    tick();
    checkOutput("tmo_req_fall", 32'(xfer_req), 0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    tick();
    tick();
    tick();
    checkOutput("tmo_count", 32'(xfer_count), 1);
    checkOutput("tmo_idle",  32'(busy),       0);

    // Set and clear on the same edge: set wins
    $display("[TB] timeout set versus clear");
    applyStimulus(1'b1, 8'h77, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 14; i++) tick();
    checkOutput("tmo2_before", 32'(timeout), 0);
    tick();
    checkOutput("tmo2_set_wins", 32'(timeout), 1);
    tick();
    checkOutput("tmo2_clr", 32'(timeout), 0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);

    // Reset while the request is still outstanding
    $display("[TB] reset mid-handshake");
    checkOutput("mid_req_before", 32'(xfer_req), 1);
    rst_n = 1'b0;
    tick();
    checkOutput("mid_req",   32'(xfer_req),   0);
    checkOutput("mid_data",  32'(xfer_data),  0);
    checkOutput("mid_count", 32'(xfer_count), 0);
    checkOutput("mid_busy",  32'(busy),       0);
    rst_n = 1'b1;
    tick();
    checkOutput("mid_ready", 32'(s_ready), 1);
    checkOutput("mid_idle",  32'(busy),    0);

    // Acknowledge stuck high through reset blocks acceptance
    $display("[TB] stuck acknowledge");
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    checkOutput("stuck_blocked", 32'(s_ready), 0);
    applyStimulus(1'b1, 8'hC3, 1'b1, 1'b0);
    tick();
    tick();
    tick();
    checkOutput("stuck_ready", 32'(s_ready),  0);
    checkOutput("stuck_req",   32'(xfer_req), 0);
    checkOutput("stuck_busy",  32'(busy),     0);
    applyStimulus(1'b1, 8'hC3, 1'b0, 1'b0);
    tick();
    checkOutput("stuck_drop1", 32'(s_ready), 0);
    tick();
    checkOutput("stuck_drop2", 32'(s_ready),  1);
    checkOutput("stuck_noreq", 32'(xfer_req), 0);
    tick();
    checkOutput("stuck_accept", 32'(xfer_req),  1);
    checkOutput("stuck_data",   32'(xfer_data), 32'h C3);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
